// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the IF/EXE SRAM request arbiter: source IDs, arbiter states,
// SRAM size codes and the request payload bundle.
package sram_req_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Source IDs stored in the in-order response FIFO
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LOCK_INST = 2'd1,
    ARB_LOCK_DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              wr;
    sram_size_e        size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  // Lock state that holds a granted-but-unaccepted source on the bridge
  function automatic arb_state_e lock_state(input logic src);
    return (src == SRC_DATA) ? ARB_LOCK_DATA : ARB_LOCK_INST;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_if.sv
// Bundle of the IF-port, EXE-port and bridge-port SRAM handshakes around the arbiter.
interface sram_req_arbiter_if;
  import sram_req_arbiter_pkg::*;

  logic              inst_req;
  logic              inst_wr;
  logic [1:0]        inst_size;
  logic [STRB_W-1:0] inst_wstrb;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_wdata;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [STRB_W-1:0] m_wstrb;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  // slave: the arbiter's view; master: requesters plus bridge around it
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );

endinterface

// File: rtl/sram_id_fifo.sv
// In-order 1-bit source-ID FIFO; head is combinational, push+pop in one cycle
// is allowed even when full.
module sram_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   push_id,
  input  logic                   pop,
  output logic                   head_id,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] id_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head_id = id_mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        id_mem[wr_ptr] <= push_id;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-handshake bridge port between IF and EXE: data-first priority
// with anti-starvation, grant lock until accept, in-order response routing.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  sram_req_arbiter_if.slave            bus,
  output logic                         busy,
  output logic [$clog2(OUTSTANDING):0] outstanding
);

  localparam int unsigned CNT_W    = $clog2(OUTSTANDING) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state;
  logic [STARVE_W-1:0] starve_cnt;

  logic             grant_vld;
  logic             grant_src;
  logic             m_req_c;
  logic             accept_c;
  logic             pop_c;
  sram_req_t        inst_pl;
  sram_req_t        data_pl;
  sram_req_t        m_pl;

  logic             fifo_full;
  logic             fifo_empty;
  logic             head_id;
  logic [CNT_W-1:0] fifo_count;

  assign inst_pl = '{wr: bus.inst_wr, size: sram_size_e'(bus.inst_size),
                     wstrb: bus.inst_wstrb, addr: bus.inst_addr, wdata: bus.inst_wdata};
  assign data_pl = '{wr: bus.data_wr, size: sram_size_e'(bus.data_size),
                     wstrb: bus.data_wstrb, addr: bus.data_addr, wdata: bus.data_wdata};

  // Grant selection; nothing is granted while reset is asserted
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_INST;
    if (resetn) begin
      unique case (state)
        ARB_LOCK_INST: begin
          grant_vld = 1'b1;
          grant_src = SRC_INST;
        end
        ARB_LOCK_DATA: begin
          grant_vld = 1'b1;
          grant_src = SRC_DATA;
        end
        default: begin
          if (!fifo_full) begin
            if (bus.inst_req && (starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
              grant_vld = 1'b1;
              grant_src = SRC_INST;
            end else if (bus.data_req) begin
              grant_vld = 1'b1;
              grant_src = SRC_DATA;
            end else if (bus.inst_req) begin
              grant_vld = 1'b1;
              grant_src = SRC_INST;
            end
          end
        end
      endcase
    end
  end

  // Request-path mux; payload reads as zero when nobody is granted
  always_comb begin
    m_req_c = 1'b0;
    m_pl    = '0;
    if (grant_vld) begin
      if (grant_src == SRC_DATA) begin
        m_req_c = bus.data_req;
        m_pl    = data_pl;
      end else begin
        m_req_c = bus.inst_req;
        m_pl    = inst_pl;
      end
    end
  end

  assign accept_c = m_req_c & bus.m_addr_ok;
  assign pop_c    = resetn & bus.m_data_ok & ~fifo_empty;

  assign bus.m_req   = m_req_c;
  assign bus.m_wr    = m_pl.wr;
  assign bus.m_size  = 2'(m_pl.size);
  assign bus.m_wstrb = m_pl.wstrb;
  assign bus.m_addr  = m_pl.addr;
  assign bus.m_wdata = m_pl.wdata;

  assign bus.inst_addr_ok = bus.m_addr_ok & grant_vld & (grant_src == SRC_INST);
  assign bus.data_addr_ok = bus.m_addr_ok & grant_vld & (grant_src == SRC_DATA);

  // Responses go to the head-of-FIFO requester; rdata fans out to both
  assign bus.inst_data_ok = pop_c & (head_id == SRC_INST);
  assign bus.data_data_ok = pop_c & (head_id == SRC_DATA);
  assign bus.inst_rdata   = bus.m_rdata;
  assign bus.data_rdata   = bus.m_rdata;

  sram_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept_c),
    .push_id (grant_src),
    .pop     (pop_c),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign outstanding = fifo_count;
  assign busy        = (fifo_count != '0);

  // Lock holds an unaccepted grant; starve_cnt counts data wins over a waiting inst
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (grant_vld && !bus.m_addr_ok) begin
            state <= lock_state(grant_src);
          end
        end
        default: begin
          if (bus.m_addr_ok) begin
            state <= ARB_IDLE;
          end
        end
      endcase

      if (!bus.inst_req || (accept_c && (grant_src == SRC_INST))) begin
        starve_cnt <= '0;
      end else if (accept_c && (grant_src == SRC_DATA) &&
                   (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a queue-based reference model.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int OUT = 4;
  localparam int LIM = 8;
  localparam int CW  = $clog2(OUT) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          busy;
  logic [CW-1:0] outstanding;

  sram_req_arbiter_if bus ();

  sram_req_arbiter #(
    .OUTSTANDING  (OUT),
    .STARVE_LIMIT (LIM)
  ) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .busy        (busy),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Reference state: issue-order IDs, source holding the bridge, data-win streak
  int mq[$];
  int lock   = -1;
  int starve = 0;
  bit acc_inst = 1'b0;
  bit acc_data = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    int head;
    logic e_req;
    logic pop;
    logic acc;
    logic [70:0] e_pl;

    if (!resetn)                               g = -1;
    else if (lock >= 0)                        g = lock;
    else if (mq.size() == OUT)                 g = -1;
    else if (bus.inst_req && starve == LIM)    g = 0;
    else if (bus.data_req)                     g = 1;
    else if (bus.inst_req)                     g = 0;
    else                                       g = -1;

    e_req = 1'b0;
    e_pl  = '0;
    if (g == 0) begin
      e_req = bus.inst_req;
      e_pl  = {bus.inst_wr, bus.inst_size, bus.inst_wstrb, bus.inst_addr, bus.inst_wdata};
    end else if (g == 1) begin
      e_req = bus.data_req;
      e_pl  = {bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata};
    end
    head = (mq.size() > 0) ? mq[0] : 0;
    pop  = resetn && bus.m_data_ok && (mq.size() > 0);

    if (chk_en) begin
      chk("m_req", 128'(bus.m_req), 128'(e_req));
      chk("m_payload", 128'({bus.m_wr, bus.m_size, bus.m_wstrb, bus.m_addr, bus.m_wdata}),
          128'(e_pl));
      chk("inst_addr_ok", 128'(bus.inst_addr_ok), 128'(bus.m_addr_ok && g == 0));
      chk("data_addr_ok", 128'(bus.data_addr_ok), 128'(bus.m_addr_ok && g == 1));
      chk("inst_data_ok", 128'(bus.inst_data_ok), 128'(pop && head == 0));
      chk("data_data_ok", 128'(bus.data_data_ok), 128'(pop && head == 1));
      chk("inst_rdata", 128'(bus.inst_rdata), 128'(bus.m_rdata));
      chk("data_rdata", 128'(bus.data_rdata), 128'(bus.m_rdata));
      chk("outstanding", 128'(outstanding), 128'(mq.size()));
      chk("busy", 128'(busy), 128'(mq.size() != 0));
    end

    acc_inst = 1'b0;
    acc_data = 1'b0;
    if (!resetn) begin
      mq.delete();
      lock   = -1;
      starve = 0;
    end else begin
      acc = (g >= 0) && bus.m_addr_ok;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(g);
      lock = (g >= 0 && !acc) ? g : -1;
      if (!bus.inst_req || (acc && g == 0)) starve = 0;
      else if (acc && g == 1 && starve < LIM) starve++;
      acc_inst = acc && (g == 0);
      acc_data = acc && (g == 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.inst_size = 2'(SIZE_WORD);
    bus.inst_wstrb = 4'h0; bus.inst_addr = '0; bus.inst_wdata = '0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'(SIZE_WORD);
    bus.data_wstrb = 4'h0; bus.data_addr = '0; bus.data_wdata = '0;
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = '0;
  endtask

  // Return every outstanding response, bounded
  task automatic drain();
    for (int i = 0; i < 2 * OUT && mq.size() != 0; i++) begin
      bus.m_data_ok = 1'b1;
      step();
    end
    bus.m_data_ok = 1'b0;
    settle();
    chk("drain_outstanding", 128'(outstanding), 128'(0));
  endtask

  initial begin
    bit ipend;
    bit dpend;
    resetn = 1'b0;
    idle_inputs();
    step(); step();
    chk_en = 1'b1;
    settle();
    chk("rst_m_req", 128'(bus.m_req), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    step();
    resetn = 1'b1;
    settle();
    chk("post_rst_m_req", 128'(bus.m_req), 128'(0));
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_inst_addr_ok", 128'(bus.inst_addr_ok), 128'(0));

    // Single inst request, response three cycles later
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0000; bus.m_addr_ok = 1'b1;
    settle();
    chk("d1_inst_addr_ok", 128'(bus.inst_addr_ok), 128'(1));
    chk("d1_m_addr", 128'(bus.m_addr), 128'(32'h1C00_0000));
    step(); idle_inputs(); settle();
    chk("d1_outstanding", 128'(outstanding), 128'(1));
    step(); step();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
    settle();
    chk("d1_inst_data_ok", 128'(bus.inst_data_ok), 128'(1));
    chk("d1_inst_rdata", 128'(bus.inst_rdata), 128'(32'hDEAD_BEEF));
    chk("d1_data_data_ok", 128'(bus.data_data_ok), 128'(0));
    step(); idle_inputs();

    // Data beats inst when both request
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0040;
    bus.data_req = 1'b1; bus.data_addr = 32'h0000_0010; bus.data_wr = 1'b1;
    bus.data_wstrb = 4'hF; bus.data_wdata = 32'h1234_5678; bus.m_addr_ok = 1'b1;
    settle();
    chk("d2_m_addr", 128'(bus.m_addr), 128'(32'h10));
    chk("d2_m_wr", 128'(bus.m_wr), 128'(1));
    chk("d2_data_addr_ok", 128'(bus.data_addr_ok), 128'(1));
    chk("d2_inst_addr_ok", 128'(bus.inst_addr_ok), 128'(0));
    step();
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_addr = '0;
    settle();
    chk("d2_inst_next", 128'(bus.inst_addr_ok), 128'(1));
    step(); idle_inputs(); drain();

    // Lock: inst stalls on the bridge while data arrives
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0100;
    settle();
    chk("d3_m_addr_c0", 128'(bus.m_addr), 128'(32'h1C00_0100));
    step();
    bus.data_req = 1'b1; bus.data_addr = 32'h0000_0200;
    settle();
    chk("d3_m_addr_c1", 128'(bus.m_addr), 128'(32'h1C00_0100));
    step(); settle();
    chk("d3_m_addr_c2", 128'(bus.m_addr), 128'(32'h1C00_0100));
    step();
    bus.m_addr_ok = 1'b1;
    settle();
    chk("d3_inst_acc", 128'(bus.inst_addr_ok), 128'(1));
    chk("d3_data_wait", 128'(bus.data_addr_ok), 128'(0));
    step();
    bus.inst_req = 1'b0; bus.inst_addr = '0;
    settle();
    chk("d3_data_acc", 128'(bus.data_addr_ok), 128'(1));
    chk("d3_m_addr_data", 128'(bus.m_addr), 128'(32'h200));
    step(); idle_inputs(); drain();

    // Full FIFO blocks grant even with a same-cycle response
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_1000; bus.m_addr_ok = 1'b1;
    for (int k = 0; k < OUT; k++) begin
      settle();
      chk($sformatf("d4_fill%0d", k), 128'(bus.inst_addr_ok), 128'(1));
      step();
      bus.inst_addr = bus.inst_addr + 32'd4;
    end
    bus.m_data_ok = 1'b1;
    settle();
    chk("d4_full_m_req", 128'(bus.m_req), 128'(0));
    chk("d4_full_outstanding", 128'(outstanding), 128'(4));
    chk("d4_full_pop", 128'(bus.inst_data_ok), 128'(1));
    step();
    bus.m_data_ok = 1'b0;
    settle();
    chk("d4_resume_m_req", 128'(bus.m_req), 128'(1));
    chk("d4_resume_outstanding", 128'(outstanding), 128'(3));
    step(); idle_inputs(); drain();

    // Ordering: inst, data, inst responses route in issue order
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_2000; bus.m_addr_ok = 1'b1;
    step();
    bus.inst_req = 1'b0; bus.data_req = 1'b1; bus.data_addr = 32'h0000_3000;
    step();
    bus.data_req = 1'b0; bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_2004;
    step();
    idle_inputs(); bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0000_0001;
    settle();
    chk("d5_cnt3", 128'(outstanding), 128'(3));
    chk("d5_r0_inst", 128'({bus.inst_data_ok, bus.data_data_ok}), 128'(2'b10));
    step(); settle();
    chk("d5_cnt2", 128'(outstanding), 128'(2));
    chk("d5_r1_data", 128'({bus.inst_data_ok, bus.data_data_ok}), 128'(2'b01));
    step(); settle();
    chk("d5_cnt1", 128'(outstanding), 128'(1));
    chk("d5_r2_inst", 128'({bus.inst_data_ok, bus.data_data_ok}), 128'(2'b10));
    step();
    bus.m_data_ok = 1'b0;
    settle();
    chk("d5_cnt0", 128'(outstanding), 128'(0));

    // Starvation: eight data wins, then inst is forced through once
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_4000;
    bus.data_req = 1'b1; bus.data_addr = 32'h0000_5000;
    bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1;
    for (int k = 0; k < LIM; k++) begin
      settle();
      chk($sformatf("d6_data%0d", k), 128'(bus.data_addr_ok), 128'(1));
      step();
      bus.data_addr = bus.data_addr + 32'd4;
    end
    settle();
    chk("d6_inst_forced", 128'(bus.inst_addr_ok), 128'(1));
    chk("d6_data_held", 128'(bus.data_addr_ok), 128'(0));
    step();
    bus.inst_addr = 32'h1C00_4004;
    settle();
    chk("d6_starve_cleared", 128'(bus.data_addr_ok), 128'(1));

    // Reset mid-stream drops all tracking
    step();
    resetn = 1'b0;
    settle();
    chk("d7_rst_m_req", 128'(bus.m_req), 128'(0));
    chk("d7_rst_data_ok", 128'({bus.inst_data_ok, bus.data_data_ok}), 128'(0));
    step();
    resetn = 1'b1; idle_inputs();
    settle();
    chk("d7_outstanding", 128'(outstanding), 128'(0));
    chk("d7_m_req", 128'(bus.m_req), 128'(0));

    // Random traffic obeying the hold-until-addr_ok protocol
    ipend = 1'b0;
    dpend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (acc_inst) ipend = 1'b0;
      if (acc_data) dpend = 1'b0;
      if (!ipend && $urandom_range(0, 99) < 60) begin
        ipend = 1'b1;
        bus.inst_wr = 1'($urandom_range(0, 1)); bus.inst_size = 2'($urandom_range(0, 2));
        bus.inst_wstrb = 4'($urandom); bus.inst_addr = $urandom; bus.inst_wdata = $urandom;
      end
      if (!dpend && $urandom_range(0, 99) < 60) begin
        dpend = 1'b1;
        bus.data_wr = 1'($urandom_range(0, 1)); bus.data_size = 2'($urandom_range(0, 2));
        bus.data_wstrb = 4'($urandom); bus.data_addr = $urandom; bus.data_wdata = $urandom;
      end
      bus.inst_req  = ipend;
      bus.data_req  = dpend;
      bus.m_addr_ok = ($urandom_range(0, 99) < 55);
      bus.m_data_ok = (mq.size() > 0) ? ($urandom_range(0, 99) < 45)
                                      : ($urandom_range(0, 99) < 3);
      bus.m_rdata   = $urandom;
      resetn        = ($urandom_range(0, 299) != 0);
    end

    step();
    idle_inputs();
    resetn = 1'b1;
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
